// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types, default sizes and count-width helper for the fetch unit
package fetch_pkg;
  localparam int FETCH_BITS = 32;
  localparam int FETCH_FIFO_DEPTH = 4;
  localparam int FETCH_MAX_OUT = 2;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
  localparam int FIFO_CNT_W = cnt_w(FETCH_FIFO_DEPTH);
  localparam int OUT_CNT_W = cnt_w(FETCH_MAX_OUT);
  typedef enum logic [1:0] {INIT, RUN, FAULT} state_t;
  typedef struct packed {
    logic [FETCH_BITS-1:0] pc;
    logic [FETCH_BITS-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous in-order buffer of fetched {pc, instr} entries with flush
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_FIFO_DEPTH,
  parameter int CW = cnt_w(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t din_i,
  output fetch_entry_t dout_o,
  output logic [CW-1:0] count_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  // storage and pointers; flush empties the buffer but leaves stale data unseen
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) mem_q[wr_q] <= din_i;
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end
  assign dout_o = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == CW'(DEPTH);
endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: PC-driven pipelined fetch with credit-limited issue; FETCH_MISALIGN_TRAP_EN adds misaligned-redirect trap
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int BITS = FETCH_BITS,
  parameter int FIFO_DEPTH = FETCH_FIFO_DEPTH,
  parameter int MAX_OUTSTANDING = FETCH_MAX_OUT,
  parameter int PC_STEP = 4,
  parameter logic [BITS-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_en,
  input  logic            redirect,
  input  logic [BITS-1:0] redirect_pc,
  output logic            proc_req,
  output logic            we,
  output logic [BITS-1:0] ADDR_OUT,
  input  logic            mem_rdy,
  input  logic            valid,
  input  logic [BITS-1:0] RDATA,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [BITS-1:0] INSTR_OUT,
  output logic [BITS-1:0] PC_OUT,
  output logic            PC_en
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            misalign_fault
`endif
);
  localparam int CW = cnt_w(FIFO_DEPTH);
  localparam int OW = cnt_w(MAX_OUTSTANDING);
  localparam int QW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  state_t state_q, state_d;
  logic [BITS-1:0] pc_q, pc_d;
  logic [OW-1:0] out_q, out_d, drop_q, drop_d;
  logic [BITS-1:0] pcq_q [MAX_OUTSTANDING];
  logic [QW-1:0] head_q, tail_q;
  logic [CW-1:0] count;
  logic accept, resp, push, pop, empty, full;
  fetch_entry_t head;
  assign resp = valid && out_q != '0;
  assign proc_req = state_q == RUN && fetch_en && !redirect && int'(out_q) < MAX_OUTSTANDING
                    && int'(count) + int'(out_q) - int'(drop_q) < FIFO_DEPTH;
  assign accept = proc_req && mem_rdy;
  assign push = resp && drop_q == '0 && !redirect;
  assign pop = !empty && instr_ready;
  assign we = 1'b0;
  assign ADDR_OUT = pc_q;
  assign PC_en = accept;
  assign instr_valid = !empty;
  assign INSTR_OUT = head.instr;
  assign PC_OUT = head.pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (redirect_pc % BITS'(PC_STEP)) != '0;
  assign misalign_fault = state_q == FAULT;
`endif
  // next state: redirect sets PC and how many in-flight responses are stale
  always_comb begin
`ifdef FETCH_MISALIGN_TRAP_EN
    state_d = redirect ? (misaligned ? FAULT : RUN) : state_q == INIT ? RUN : state_q;
`else
    state_d = state_q == INIT ? RUN : state_q;
`endif
    pc_d = redirect ? redirect_pc : accept ? pc_q + BITS'(PC_STEP) : pc_q;
    out_d = out_q + OW'(accept) - OW'(resp);
    drop_d = redirect ? out_q - OW'(resp) : resp && drop_q != '0 ? drop_q - OW'(1) : drop_q;
  end
  // control registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT;
      pc_q <= RESET_PC;
      out_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      out_q <= out_d;
      drop_q <= drop_d;
    end
  end
  // request-PC queue pairs each response with the address that produced it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) pcq_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (accept) pcq_q[tail_q] <= pc_q;
      if (accept) tail_q <= tail_q == QW'(MAX_OUTSTANDING - 1) ? '0 : tail_q + QW'(1);
      if (resp) head_q <= head_q == QW'(MAX_OUTSTANDING - 1) ? '0 : head_q + QW'(1);
    end
  end
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_buf (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .pop_i  (pop),
    .flush_i(redirect),
    .din_i  ('{pc: pcq_q[head_q], instr: RDATA}),
    .dout_o (head),
    .count_o(count),
    .empty_o(empty),
    .full_o (full)
  );
  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst) !(valid && out_q == '0));
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst) !(push && full));
endmodule
